// File: rtl/output_deskew_collector_pkg.sv
// Shared constants and types for the output deskew collector.
package output_deskew_collector_pkg;

  localparam int unsigned ARRAYWIDTH = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ROWS       = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned LANE_W = DATA_W;
  localparam int unsigned ROW_W  = ARRAYWIDTH * LANE_W;

  typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/output_deskew_collector_row_fifo.sv
// Synchronous row FIFO with wrap-bit pointers; a read frees a slot for a same-cycle write.
module output_deskew_collector_row_fifo
  import output_deskew_collector_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH,
  parameter int unsigned Width = ROW_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/output_deskew_collector.sv
// Realigns diagonally skewed array results into rows, buffers them and streams them out.
// Optional DESKEW_DROP_CNT_EN adds a saturating drop_cnt output.
module output_deskew_collector
  import output_deskew_collector_pkg::*;
#(
  parameter int unsigned ArrayWidth = ARRAYWIDTH,
  parameter int unsigned DataW      = DATA_W,
  parameter int unsigned Rows       = ROWS,
  parameter int unsigned FifoDepth  = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [ArrayWidth*DataW-1:0] in_sum,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ArrayWidth*DataW-1:0] out_row,
  output logic                        out_last,
  output logic                        overflow
`ifdef DESKEW_DROP_CNT_EN
  ,
  output logic [7:0]                  drop_cnt
`endif
);

  localparam int unsigned RowW    = ArrayWidth * DataW;
  localparam int unsigned CntW    = $clog2(FifoDepth) + 1;
  localparam int unsigned FlightW = $clog2(ArrayWidth) + 1;
  localparam int unsigned TileW   = (Rows > 1) ? $clog2(Rows) : 1;

  logic [RowW-1:0]         aligned;
  logic [ArrayWidth-2:0]   vld_q;
  logic                    row_done;
  logic [RowW-1:0]         head;
  logic [CntW-1:0]         fifo_count;
  logic                    fifo_full, fifo_empty;
  logic                    rd_en, wr_en, drop;
  logic [FlightW-1:0]      inflight_q, inflight_d;
  logic [TileW-1:0]        tile_q, tile_d;

  // Lane j arrives j cycles late, so it is held for ArrayWidth-1-j cycles.
  for (genvar j = 0; j < ArrayWidth; j++) begin : g_lane
    localparam int unsigned Dly = ArrayWidth - 1 - j;
    if (Dly == 0) begin : g_pass
      assign aligned[j*DataW +: DataW] = in_sum[j*DataW +: DataW];
    end else begin : g_dly
      logic [DataW-1:0] dly_q [Dly];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < Dly; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= in_sum[j*DataW +: DataW];
          for (int k = 1; k < Dly; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned[j*DataW +: DataW] = dly_q[Dly-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < ArrayWidth - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign row_done = vld_q[ArrayWidth-2];

  assign rd_en = !fifo_empty && out_ready;
  assign wr_en = row_done && (!fifo_full || rd_en);
  assign drop  = row_done && fifo_full && !rd_en;

  output_deskew_collector_row_fifo #(
    .Depth (FifoDepth),
    .Width (RowW)
  ) u_row_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_en),
    .wr_data_i (aligned),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (in_valid && !row_done) begin
      inflight_d = inflight_q + {{(FlightW-1){1'b0}}, 1'b1};
    end else if (!in_valid && row_done) begin
      inflight_d = inflight_q - {{(FlightW-1){1'b0}}, 1'b1};
    end

    tile_d = tile_q;
    if (rd_en) tile_d = (tile_q == TileW'(Rows - 1)) ? '0 : tile_q + {{(TileW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= '0;
      tile_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      tile_q     <= tile_d;
    end
  end

  // Credit covers both buffered rows and rows still travelling through the skew path.
  assign in_ready  = (32'(fifo_count) + 32'(inflight_q)) < FifoDepth;
  assign out_valid = !fifo_empty;
  assign out_row   = fifo_empty ? '0 : head;
  assign out_last  = !fifo_empty && (tile_q == TileW'(Rows - 1));

`ifdef DESKEW_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != 8'd0);
`else
  logic overflow_q, overflow_d;

  assign overflow_d = overflow_q | drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule
